// File: rtl/banner_uart_reporter_if.sv
// Byte handshake between the banner reporter and a uart_tx instance.
// Ports:
//   tx_start     reporter -> uart_tx : 1-cycle launch pulse for tx_din
//   tx_din       reporter -> uart_tx : byte to transmit, held until acknowledged
//   tx_done_tick uart_tx  -> reporter: current byte fully shifted out
interface banner_uart_reporter_if;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_done_tick;

    modport master (
        output tx_start,
        output tx_din,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  tx_din,
        output tx_done_tick
    );
endinterface

// File: rtl/banner_uart_reporter.sv
// Snapshots the D displayed 5-bit chars on request and sends them as an ASCII line over the UART TX byte handshake.
// Latency: first tx_start the cycle after report_req; next byte's tx_start 2 cycles after each tx_done_tick.
// Backpressure: one byte in flight, waits for tx_done_tick (timeout abort); requests while busy coalesce into one extra line.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_report_req    1-cycle pulse requesting one report line
//   i_disp          display chars, [5*D-1 -: 5] is the leftmost char
//   tx_if           master side of the uart_tx byte handshake
//   o_busy          high from snapshot until line completes or aborts
//   o_line_done     1-cycle pulse after the last byte is acknowledged
//   o_tx_err        1-cycle pulse when a byte times out and the line is aborted
module banner_uart_reporter #(
    parameter int D         = 6,
    parameter int CRLF      = 1,
    parameter int TO_CYCLES = 200_000,
    parameter int TO_W      = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_report_req,
    input  logic [5*D-1:0]         i_disp,
    banner_uart_reporter_if.master tx_if,
    output logic                   o_busy,
    output logic                   o_line_done,
    output logic                   o_tx_err
);
    localparam int L  = D + 2 * CRLF;
    localparam int IW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_NEXT} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [5*D-1:0] r_snap;
    logic [IW-1:0]  r_idx;
    logic [TO_W-1:0] r_cnt;
    logic           r_pending;

    logic           w_last;
    logic           w_timeout;
    logic           w_restart;
    logic [4:0]     w_char;
    logic [7:0]     w_byte;

    function automatic logic [7:0] encode(input logic [4:0] c);
        if (c[4])
            return 8'h20;
        else if (c[3:0] <= 4'd9)
            return 8'h30 + {4'h0, c[3:0]};
        else
            return 8'h37 + {4'h0, c[3:0]};   // 0x41 + (c - 10)
    endfunction

    assign w_last    = (r_idx == IW'(L - 1));
    assign w_timeout = (r_cnt == TO_W'(TO_CYCLES));
    // A request arriving in the completion cycle is treated like a pending one.
    assign w_restart = w_last && (r_pending || i_report_req);

    always_comb begin
        w_char = '0;
        for (int i = 0; i < D; i++) begin
            if (r_idx == IW'(i))
                w_char = r_snap[(D-1-i)*5 +: 5];
        end
        w_byte = encode(w_char);
        if (CRLF != 0 && r_idx == IW'(D))
            w_byte = 8'h0D;
        if (CRLF != 0 && r_idx == IW'(D + 1))
            w_byte = 8'h0A;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_report_req) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (tx_if.tx_done_tick)
                    w_next = S_NEXT;
                else if (w_timeout)
                    w_next = S_IDLE;
            end
            S_NEXT:  w_next = (!w_last || w_restart) ? S_START : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs; tx_din is only driven while a byte is being launched or awaited.
    always_comb begin
        tx_if.tx_start = (r_state == S_START);
        tx_if.tx_din   = (r_state == S_START || r_state == S_WAIT) ? w_byte : 8'h00;
        o_busy         = (r_state != S_IDLE);
        o_line_done    = (r_state == S_NEXT) && w_last;
        o_tx_err       = (r_state == S_WAIT) && !tx_if.tx_done_tick && w_timeout;
    end

    // Datapath: snapshot, byte index, timeout counter, coalesced pending request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_report_req) begin
                        r_snap <= i_disp;
                        r_idx  <= '0;
                    end
                end
                S_START: begin
                    r_cnt <= '0;
                    if (i_report_req)
                        r_pending <= 1'b1;
                end
                S_WAIT: begin
                    if (!tx_if.tx_done_tick && w_timeout) begin
                        r_pending <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                        if (i_report_req)
                            r_pending <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_pending <= 1'b0;
                        if (w_restart) begin
                            r_snap <= i_disp;
                            r_idx  <= '0;
                        end
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        if (i_report_req)
                            r_pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_banner_uart_reporter.sv
module tb_banner_uart_reporter;
    localparam int D  = 6;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           report_req = 1'b0;
    logic [5*D-1:0] disp = '0;
    logic           busy, line_done, tx_err;

    banner_uart_reporter_if tx_if ();

    banner_uart_reporter #(.D(D), .CRLF(1), .TO_CYCLES(TO), .TO_W(18)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_report_req (report_req),
        .i_disp       (disp),
        .tx_if        (tx_if),
        .o_busy       (busy),
        .o_line_done  (line_done),
        .o_tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int starts_cnt = 0;
    int lines_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    // uart_tx model state
    bit mute = 1'b0;
    bit m_busy = 1'b0;
    int m_cnt = 0;
    int lat = 4;

    // monitor state
    bit         holding = 1'b0;
    bit         stable = 1'b1;
    logic [7:0] held = 8'h00;

    function automatic logic [7:0] enc(input logic [4:0] c);
        if (c[4] == 1'b1) return 8'h20;
        if (c[3:0] < 4'd10) return 8'h30 + 8'(c[3:0]);
        return 8'h41 + 8'(c[3:0]) - 8'd10;
    endfunction

    task automatic push_line(input logic [5*D-1:0] d);
        for (int i = 0; i < D; i++) exp_q.push_back(enc(d[(D-1-i)*5 +: 5]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 report_req = 1'b1;
        @(posedge clk); #1 report_req = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) begin timed_out = 1'b0; break; end
        end
        @(posedge clk); #1;
    endtask

    // uart_tx model followed by the scoreboard monitor, sequenced in one loop
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_if.tx_done_tick = 1'b0;
                m_busy  = 1'b0;
                holding = 1'b0;
            end else begin
                tx_if.tx_done_tick = 1'b0;
                if (m_busy) begin
                    if (m_cnt == 0) begin tx_if.tx_done_tick = 1'b1; m_busy = 1'b0; end
                    else m_cnt--;
                end
                if (tx_if.tx_start) begin
                    starts_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL byte_unexpected: got %h, expected no byte", tx_if.tx_din);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_if.tx_din !== e) begin
                            errors++;
                            $display("FAIL byte_value: got %h, expected %h", tx_if.tx_din, e);
                        end
                    end
                    if (!mute) begin
                        checks++;
                        if (m_busy) begin
                            errors++;
                            $display("FAIL start_overlap: tx_start=1 with byte unacknowledged, expected 0");
                        end
                        m_busy = 1'b1;
                        m_cnt  = lat;
                    end
                    held = tx_if.tx_din; holding = 1'b1; stable = 1'b1;
                end else if (holding) begin
                    if (tx_if.tx_din !== held) stable = 1'b0;
                    if (tx_if.tx_done_tick) begin
                        checks++;
                        if (!stable) begin
                            errors++;
                            $display("FAIL din_stable: tx_din changed from %h before tx_done_tick, expected held", held);
                        end
                        holding = 1'b0;
                    end
                end
                if (line_done) lines_cnt++;
                if (tx_err) begin err_cnt++; holding = 1'b0; end
            end
        end
    end

    task automatic test_reset();
        #1;
        checks++; if (tx_if.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b, expected 0", tx_if.tx_start); end
        checks++; if (tx_if.tx_din !== 8'h00) begin errors++; $display("FAIL reset_tx_din: got %h, expected 00", tx_if.tx_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (line_done !== 1'b0 || tx_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b err=%b, expected 0 0", line_done, tx_err); end
        #22 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_basic();
        int s0, l0; bit to;
        disp = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        s0 = starts_cnt; l0 = lines_cnt;
        push_line(disp);
        pulse_req();
        @(negedge clk);
        checks++; if (tx_if.tx_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL first_latency: got start=%b busy=%b, expected 1 1", tx_if.tx_start, busy); end
        wait_idle(1000, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: busy stuck 1, expected 0"); end
        checks++; if (starts_cnt - s0 != 8) begin errors++; $display("FAIL basic_starts: got %0d, expected 8", starts_cnt - s0); end
        checks++; if (lines_cnt - l0 != 1) begin errors++; $display("FAIL basic_lines: got %0d, expected 1", lines_cnt - l0); end
    endtask

    task automatic test_encode();
        int l0; bit to;
        disp = {5'h0A, 5'h0F, 5'h10, 5'h09, 5'h1F, 5'h00};
        l0 = lines_cnt;
        push_line(disp);
        pulse_req();
        wait_idle(1000, to);
        checks++; if (to || lines_cnt - l0 != 1) begin errors++; $display("FAIL encode_line: got lines=%0d timeout=%b, expected 1 0", lines_cnt - l0, to); end
    endtask

    task automatic test_coalesce();
        int s0, l0; bit to;
        logic [5*D-1:0] b;
        disp = {5'd7, 5'd8, 5'd9, 5'hB, 5'hC, 5'hD};
        b    = {5'hE, 5'h1, 5'h12, 5'h3, 5'hA, 5'd6};
        s0 = starts_cnt; l0 = lines_cnt;
        push_line(disp);
        pulse_req();
        repeat (3) @(posedge clk);
        #1 disp = b;
        push_line(b);
        for (int i = 0; i < 3; i++) begin pulse_req(); repeat (4) @(posedge clk); end
        wait_idle(3000, to);
        checks++; if (to) begin errors++; $display("FAIL coalesce_timeout: busy stuck 1, expected 0"); end
        checks++; if (lines_cnt - l0 != 2) begin errors++; $display("FAIL coalesce_lines: got %0d, expected 2", lines_cnt - l0); end
        checks++; if (starts_cnt - s0 != 16) begin errors++; $display("FAIL coalesce_starts: got %0d, expected 16", starts_cnt - s0); end
    endtask

    task automatic test_req_at_completion();
        int s0, l0; bit to; bit hit;
        disp = {5'd1, 5'd2, 5'h1F, 5'hF, 5'hE, 5'd9};
        s0 = starts_cnt; l0 = lines_cnt; hit = 1'b0;
        push_line(disp);
        pulse_req();
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (starts_cnt == s0 + 8 && tx_if.tx_done_tick) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL completion_reach: last tick not seen, expected seen"); end
        #1 report_req = 1'b1;
        push_line(disp);
        @(posedge clk); #1 report_req = 1'b0;
        wait_idle(2000, to);
        checks++; if (to || lines_cnt - l0 != 2) begin errors++; $display("FAIL completion_lines: got %0d, expected 2", lines_cnt - l0); end
    endtask

    task automatic test_timeout();
        int n, l0; bit to;
        disp = {5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3};
        mute = 1'b1;
        l0 = lines_cnt;
        exp_q.push_back(8'h33);
        pulse_req();
        @(negedge clk);
        checks++; if (tx_if.tx_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b, expected 1", tx_if.tx_start); end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); n++;
            if (tx_err) break;
        end
        checks++; if (n != TO + 1) begin errors++; $display("FAIL to_delay: got %0d cycles, expected %0d", n, TO + 1); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_err !== 1'b0) begin errors++; $display("FAIL to_after: got busy=%b err=%b, expected 0 0", busy, tx_err); end
        @(posedge clk); #1;
        checks++; if (lines_cnt != l0) begin errors++; $display("FAIL to_no_done: got %0d line_done, expected 0", lines_cnt - l0); end
        mute = 1'b0;
        push_line(disp);
        pulse_req();
        wait_idle(1000, to);
        checks++; if (to || lines_cnt - l0 != 1) begin errors++; $display("FAIL to_recover: got lines=%0d, expected 1", lines_cnt - l0); end
    endtask

    task automatic test_reset_mid();
        int s0, l0; bit to; bit hit;
        disp = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4};
        s0 = starts_cnt; hit = 1'b0;
        push_line(disp);
        pulse_req();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (starts_cnt == s0 + 3) begin hit = 1'b1; break; end
        end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (!hit || busy !== 1'b0 || tx_if.tx_din !== 8'h00 || tx_if.tx_start !== 1'b0 || line_done !== 1'b0 || tx_err !== 1'b0)
            begin errors++; $display("FAIL mid_reset_outputs: got hit=%b busy=%b din=%h start=%b, expected 1 0 00 0", hit, busy, tx_if.tx_din, tx_if.tx_start); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        s0 = starts_cnt;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        checks++; if (starts_cnt != s0) begin errors++; $display("FAIL mid_reset_idle: got %0d starts, expected 0", starts_cnt - s0); end
        l0 = lines_cnt;
        push_line(disp);
        pulse_req();
        wait_idle(1000, to);
        checks++; if (to || starts_cnt - s0 != 8 || lines_cnt - l0 != 1) begin errors++; $display("FAIL mid_reset_restart: got starts=%0d lines=%0d, expected 8 1", starts_cnt - s0, lines_cnt - l0); end
    endtask

    task automatic test_snapshot();
        int l0; bit to;
        disp = {5'hA, 5'hB, 5'hC, 5'hD, 5'hE, 5'hF};
        l0 = lines_cnt;
        push_line(disp);
        pulse_req();
        disp = {5'd0, 5'd0, 5'h10, 5'h10, 5'd1, 5'd1};
        wait_idle(1000, to);
        checks++; if (to || lines_cnt - l0 != 1) begin errors++; $display("FAIL snapshot_line: got lines=%0d, expected 1", lines_cnt - l0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_encode();
        test_coalesce();
        test_req_at_completion();
        test_timeout();
        test_reset_mid();
        lat = 0;
        test_snapshot();
        lat = 4;
        repeat (5) @(posedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drained: got %0d bytes left, expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
